// File: rtl/pixel_writer_pkg.sv
// Shared GPU definitions used by the pixel writer and its FIFO.
//   WIDTH_BITS / HEIGHT_BITS : pixel coordinate widths (X / Y)
//   CHANNEL_BITS             : bits per colour channel
//   FB_ADDR_BITS             : framebuffer word address width
//   PIXEL_DATA_BITS          : packed {r,g,b} word width
//   pw_state_e               : pixel_writer output-stage FSM states
package pixel_writer_pkg;

  localparam int unsigned WIDTH_BITS      = 10;
  localparam int unsigned HEIGHT_BITS     = 9;
  localparam int unsigned CHANNEL_BITS    = 8;
  localparam int unsigned FB_ADDR_BITS    = 19;
  localparam int unsigned PIXEL_DATA_BITS = 3 * CHANNEL_BITS;

  typedef enum logic {
    PW_IDLE = 1'b0,
    PW_REQ  = 1'b1
  } pw_state_e;

endpackage

// File: rtl/pixel_writer_fifo.sv
// pix_fifo: parameterised synchronous FIFO with registered storage.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   : write an entry (caller must not push when full)
//   pop           : drop the head entry (caller must not pop when empty)
//   rdata         : head entry, valid while !empty
//   full, empty   : occupancy flags
module pix_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: receives rasterizer pixels, clips them to the screen,
// converts to a linear framebuffer address, buffers them and issues one
// framebuffer write per pixel on a req/ack port.
//   clk, rst                  : clock, synchronous active-high reset
//   pix_valid/pix_ready       : pixel handshake; X, Y, r_i, g_i, b_i payload
//   mem_req/mem_ack           : write request / one-cycle acknowledge
//   mem_addr, mem_wdata       : write address and packed {r,g,b}
//   clear_counts              : zero both counters
//   idle                      : nothing buffered or in flight
//   written_count             : saturating count of completed writes
//   clipped_count             : saturating count of clipped pixels
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_BITS  = FB_ADDR_BITS,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [WIDTH_BITS-1:0]      X,
  input  logic [HEIGHT_BITS-1:0]     Y,
  input  logic [CHANNEL_BITS-1:0]    r_i,
  input  logic [CHANNEL_BITS-1:0]    g_i,
  input  logic [CHANNEL_BITS-1:0]    b_i,
  output logic                       mem_req,
  output logic [ADDR_BITS-1:0]       mem_addr,
  output logic [PIXEL_DATA_BITS-1:0] mem_wdata,
  input  logic                       mem_ack,
  input  logic                       clear_counts,
  output logic                       idle,
  output logic [19:0]                written_count,
  output logic [15:0]                clipped_count
);

  localparam int unsigned ENTRY_W = ADDR_BITS + PIXEL_DATA_BITS;

  pw_state_e                  state_q, state_d;
  logic                       mem_req_q, mem_req_d;
  logic [ADDR_BITS-1:0]       mem_addr_q, mem_addr_d;
  logic [PIXEL_DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [19:0]                written_q, written_d;
  logic [15:0]                clipped_q, clipped_d;

  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ENTRY_W-1:0]   fifo_wdata, fifo_rdata;
  logic                 accept, clip, wr_done;
  logic [ADDR_BITS-1:0] pix_addr;

  assign pix_ready = !fifo_full;
  assign accept    = pix_valid && pix_ready;
  assign clip      = (32'(X) >= SCREEN_W) || (32'(Y) >= SCREEN_H);
  assign pix_addr  = ADDR_BITS'(BASE_ADDR + 32'(Y) * SCREEN_W + 32'(X));
  assign fifo_push = accept && !clip;
  assign fifo_wdata = {pix_addr, r_i, g_i, b_i};

  pix_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output stage: the head is popped into mem_addr/mem_wdata when loaded,
  // so the block holds FIFO_DEPTH + 1 pixels in total.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fifo_pop    = 1'b0;
    wr_done     = 1'b0;
    case (state_q)
      PW_IDLE: begin
        if (!fifo_empty) begin
          {mem_addr_d, mem_wdata_d} = fifo_rdata;
          fifo_pop  = 1'b1;
          mem_req_d = 1'b1;
          state_d   = PW_REQ;
        end
      end
      PW_REQ: begin
        if (mem_ack) begin
          wr_done = 1'b1;
          if (!fifo_empty) begin
            {mem_addr_d, mem_wdata_d} = fifo_rdata;
            fifo_pop = 1'b1;
          end else begin
            mem_req_d = 1'b0;
            state_d   = PW_IDLE;
          end
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = PW_IDLE;
      end
    endcase
  end

  always_comb begin
    written_d = written_q;
    clipped_d = clipped_q;
    if (clear_counts) begin
      written_d = '0;
      clipped_d = '0;
    end else begin
      if (wr_done && written_q != '1) written_d = written_q + 1'b1;
      if (accept && clip && clipped_q != '1) clipped_d = clipped_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PW_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      written_q   <= '0;
      clipped_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      written_q   <= written_d;
      clipped_q   <= clipped_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign written_count = written_q;
  assign clipped_count = clipped_q;
  assign idle          = fifo_empty && (state_q == PW_IDLE);

endmodule

// File: tb/tb_pixel_writer.sv
module tb_pixel_writer;
  import pixel_writer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_valid = 1'b0;
  logic mem_ack = 1'b0;
  logic clear_counts = 1'b0;
  logic [WIDTH_BITS-1:0]   X = '0;
  logic [HEIGHT_BITS-1:0]  Y = '0;
  logic [CHANNEL_BITS-1:0] r_i = '0, g_i = '0, b_i = '0;
  logic                    pix_ready, mem_req, idle;
  logic [18:0]             mem_addr;
  logic [23:0]             mem_wdata;
  logic [19:0]             written_count;
  logic [15:0]             clipped_count;

  pixel_writer #(
    .SCREEN_W   (640),
    .SCREEN_H   (480),
    .FIFO_DEPTH (4),
    .ADDR_BITS  (19),
    .BASE_ADDR  (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .X             (X),
    .Y             (Y),
    .r_i           (r_i),
    .g_i           (g_i),
    .b_i           (b_i),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .clear_counts  (clear_counts),
    .idle          (idle),
    .written_count (written_count),
    .clipped_count (clipped_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] a;
    logic [23:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   wr_cyc_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a write completes on the next rising edge when mem_req && mem_ack.
  logic        prev_pending = 1'b0;
  logic [18:0] prev_addr = '0;
  logic [23:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending && mem_req) begin
        chk("hold_addr", 64'(mem_addr), 64'(prev_addr));
        chk("hold_data", 64'(mem_wdata), 64'(prev_data));
      end
      if (mem_req && mem_ack) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(mem_addr), 64'h7FFFFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.a));
          chk("wr_data", 64'(mem_wdata), 64'(e.d));
        end
      end
      prev_pending = mem_req && !mem_ack;
      prev_addr    = mem_addr;
      prev_data    = mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one pixel and returns just after the edge that accepts it.
  // pix_valid is left high so callers can stream back-to-back.
  task automatic send(input int x, input int y, input logic [23:0] rgb,
                      input bit clipped, input int exp_addr);
    int n;
    logic [31:0] xv, yv, av;
    xv = x; yv = y; av = exp_addr;
    X = xv[WIDTH_BITS-1:0];
    Y = yv[HEIGHT_BITS-1:0];
    {r_i, g_i, b_i} = rgb;
    pix_valid = 1'b1;
    n = 0;
    while (!pix_ready && n < 100) begin
      step();
      n++;
    end
    if (!pix_ready) begin
      chk("send_ready_timeout", 64'(pix_ready), 64'd1);
    end else if (!clipped) begin
      exp_q.push_back('{a: av[18:0], d: rgb});
    end
    step();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 400) begin
      step();
      n++;
    end
    chk(name, 64'(exp_q.size() == 0 && idle), 64'd1);
  endtask

  task automatic clear();
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int cx, cy, d;

    // Reset held 2 cycles with a valid pixel on the inputs.
    X = 10'd5; Y = 9'd5; pix_valid = 1'b1; mem_ack = 1'b1;
    step();
    step();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_pix_ready", 64'(pix_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_written", 64'(written_count), 64'd0);
    chk("rst_clipped", 64'(clipped_count), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    pix_valid = 1'b0;
    step();
    chk("post_rst_idle", 64'(idle), 64'd1);
    chk("post_rst_req", 64'(mem_req), 64'd0);

    // Centre pixel: request appears two edges after acceptance, for one cycle.
    send(320, 240, 24'hFFFFFF, 1'b0, 153920);
    pix_valid = 1'b0;
    chk("ctr_req_lat1", 64'(mem_req), 64'd0);
    step();
    chk("ctr_req_lat2", 64'(mem_req), 64'd1);
    chk("ctr_addr", 64'(mem_addr), 64'd153920);
    chk("ctr_data", 64'(mem_wdata), 64'hFFFFFF);
    step();
    chk("ctr_req_drop", 64'(mem_req), 64'd0);
    chk("ctr_written", 64'(written_count), 64'd1);
    chk("ctr_idle", 64'(idle), 64'd1);

    // Clipping at the right and bottom edges, corner pixel kept.
    clear();
    chk("clear_written", 64'(written_count), 64'd0);
    send(640, 0, 24'h112233, 1'b1, 0);
    send(0, 480, 24'h445566, 1'b1, 0);
    send(639, 479, 24'h778899, 1'b0, 307199);
    pix_valid = 1'b0;
    drain("clip_drain");
    chk("clip_clipped", 64'(clipped_count), 64'd2);
    chk("clip_written", 64'(written_count), 64'd1);
    clear();
    chk("clear_clipped", 64'(clipped_count), 64'd0);

    // Backpressure: ack held low, 8 cycles of valid pixels.
    mem_ack = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      X = 10'(acc);
      Y = 9'd10;
      r_i = 8'(acc); g_i = 8'hA5; b_i = 8'h5A;
      pix_valid = 1'b1;
      if (pix_ready) begin
        exp_q.push_back('{a: 19'(6400 + acc), d: {8'(acc), 8'hA5, 8'h5A}});
        acc++;
      end
      step();
    end
    pix_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_ready_low", 64'(pix_ready), 64'd0);
    chk("bp_req_held", 64'(mem_req), 64'd1);
    step();
    step();
    mem_ack = 1'b1;
    step();
    chk("bp_ready_back", 64'(pix_ready), 64'd1);
    drain("bp_drain");
    chk("bp_written", 64'(written_count), 64'd5);

    // Streaming: 100 points of a radius-200 circle, one write per cycle.
    clear();
    wr_cyc_q.delete();
    mem_ack = 1'b1;
    cx = 0; cy = 200; d = 1 - 200;
    for (int i = 0; i < 100; i++) begin
      send(320 + cx, 240 - cy, {8'(cx), 8'(cy), 8'(i)}, 1'b0,
           (240 - cy) * 640 + 320 + cx);
      cx++;
      if (d < 0) begin
        d = d + 2 * cx + 1;
      end else begin
        cy--;
        d = d + 2 * (cx - cy) + 1;
      end
    end
    pix_valid = 1'b0;
    drain("strm_drain");
    chk("strm_nwrites", 64'(wr_cyc_q.size()), 64'd100);
    if (wr_cyc_q.size() == 100)
      chk("strm_back_to_back", 64'(wr_cyc_q[99] - wr_cyc_q[0]), 64'd99);
    chk("strm_written", 64'(written_count), 64'd100);

    // Reset with one write in flight and three pixels buffered.
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1, 1 + i, 24'h0F0F0F, 1'b0, (1 + i) * 640 + 1);
    end
    pix_valid = 1'b0;
    chk("mid_req_before", 64'(mem_req), 64'd1);
    chk("mid_idle_before", 64'(idle), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_req_after", 64'(mem_req), 64'd0);
    chk("mid_idle_after", 64'(idle), 64'd1);
    chk("mid_written", 64'(written_count), 64'd0);
    chk("mid_clipped", 64'(clipped_count), 64'd0);
    mem_ack = 1'b1;
    repeat (10) step();
    chk("mid_no_writes", 64'(written_count), 64'd0);
    chk("mid_req_quiet", 64'(mem_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
